// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port unified memory between the core's
// instruction-fetch port and data port, serialising accesses and stalling
// the port(s) whose access has not yet completed.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   inst_ren_i          fetch request
//   inst_addr_i         fetch byte address
//   inst_data_o         fetched word (registered)
//   inst_stall_o        fetch not yet complete
//   mem_ren_i           data read request
//   mem_wen_i           data write request (wins over mem_ren_i)
//   mem_addr_i          data byte address
//   mem_dout_i          store data from core
//   mem_din_o           load data to core (registered)
//   data_stall_o        data access not yet complete
//   ram_cs_o            memory chip select, one pulse per access
//   ram_we_o            memory write enable, valid with ram_cs_o
//   ram_addr_o          memory word address
//   ram_din_o           memory write data
//   ram_dout_i          memory read data, LATENCY cycles after ram_cs_o
//
// Config macro: MEM_ARB_RR_EN
//   undefined -> data port always wins a conflict
//   defined   -> round-robin between ports on conflicts only
module mem_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  inst_ren_i,
    input  logic [31:0]           inst_addr_i,
    output logic [31:0]           inst_data_o,
    output logic                  inst_stall_o,
    input  logic                  mem_ren_i,
    input  logic                  mem_wen_i,
    input  logic [31:0]           mem_addr_i,
    input  logic [31:0]           mem_dout_i,
    output logic [31:0]           mem_din_o,
    output logic                  data_stall_o,
    output logic                  ram_cs_o,
    output logic                  ram_we_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [31:0]           ram_din_o,
    input  logic [31:0]           ram_dout_i
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    logic [1:0]            state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [31:0]           inst_data_q, inst_data_d;
    logic [31:0]           mem_din_q, mem_din_d;

    logic data_req;
    logic conflict;
    logic grant_data;

    assign data_req = mem_ren_i | mem_wen_i;
    assign conflict = inst_ren_i & data_req;

`ifdef MEM_ARB_RR_EN
    // rr_q = 1: data port won the last conflict, so fetch wins the next one
    logic rr_q, rr_d;

    assign grant_data = conflict ? ~rr_q : data_req;

    always_comb begin
        rr_d = rr_q;
        if (state_q == S_IDLE && conflict) begin
            rr_d = grant_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q <= 1'b1;
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    assign grant_data = data_req;
`endif

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        inst_data_d = inst_data_q;
        mem_din_d   = mem_din_q;
        unique case (state_q)
            S_IDLE: begin
                if (inst_ren_i | data_req) begin
                    owner_d = grant_data ? OWN_DATA : OWN_INST;
                    we_d    = grant_data & mem_wen_i;
                    addr_d  = grant_data
                            ? mem_addr_i[ADDR_WIDTH+1:2]
                            : inst_addr_i[ADDR_WIDTH+1:2];
                    wdata_d = mem_dout_i;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (we_q) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d   = CNT_LOAD;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    if (owner_q == OWN_DATA) begin
                        mem_din_d = ram_dout_i;
                    end else begin
                        inst_data_d = ram_dout_i;
                    end
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_INST;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            inst_data_q <= '0;
            mem_din_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            inst_data_q <= inst_data_d;
            mem_din_q   <= mem_din_d;
        end
    end

    // Stall holds until the owner's RESP cycle; forced low during reset
    assign inst_stall_o = ~rst_i & inst_ren_i
                        & ~(state_q == S_RESP && owner_q == OWN_INST);
    assign data_stall_o = ~rst_i & data_req
                        & ~(state_q == S_RESP && owner_q == OWN_DATA);

    assign ram_cs_o    = (state_q == S_ISSUE);
    assign ram_we_o    = ram_cs_o & we_q;
    assign ram_addr_o  = addr_q;
    assign ram_din_o   = wdata_q;
    assign inst_data_o = inst_data_q;
    assign mem_din_o   = mem_din_q;

    // Byte-offset and above-memory address bits are intentionally ignored
    logic unused_addr_bits;
    assign unused_addr_bits = ^{inst_addr_i[1:0], mem_addr_i[1:0],
                                inst_addr_i[31:ADDR_WIDTH+2],
                                mem_addr_i[31:ADDR_WIDTH+2]};

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized scoreboard bench for mem_arbiter with a
// transaction-level timing/memory model and a behavioural unified memory.
module tb_mem_arbiter;

    localparam int AW  = 10;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          inst_ren;
    logic [31:0]   inst_addr;
    logic [31:0]   inst_data;
    logic          inst_stall;
    logic          mem_ren;
    logic          mem_wen;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_dout;
    logic [31:0]   mem_din;
    logic          data_stall;
    logic          ram_cs;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_din;
    logic [31:0]   ram_dout;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
        .clk_i(clk), .rst_i(rst),
        .inst_ren_i(inst_ren), .inst_addr_i(inst_addr),
        .inst_data_o(inst_data), .inst_stall_o(inst_stall),
        .mem_ren_i(mem_ren), .mem_wen_i(mem_wen),
        .mem_addr_i(mem_addr), .mem_dout_i(mem_dout),
        .mem_din_o(mem_din), .data_stall_o(data_stall),
        .ram_cs_o(ram_cs), .ram_we_o(ram_we),
        .ram_addr_o(ram_addr), .ram_din_o(ram_din),
        .ram_dout_i(ram_dout)
    );

    function automatic logic [31:0] f_init(int i);
        if (i == 2) return 32'h2402_0005;
        return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
    endfunction

    // Behavioural unified memory with LAT-cycle read pipeline
    logic [31:0]    mem [1<<AW];
    logic           minit = 1'b0;
    logic [LAT-1:0] pv = '0;
    logic [31:0]    pd [LAT];
    logic [31:0]    garb = 32'h0BAD_0BAD;

    always @(posedge clk) begin
        garb <= $urandom;
        if (rst && !minit) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= f_init(i);
            minit <= 1'b1;
        end else if (ram_cs && ram_we) begin
            mem[ram_addr] <= ram_din;
        end
        pv    <= {pv[LAT-2:0], ram_cs & ~ram_we};
        pd[0] <= mem[ram_addr];
        for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
    end

    assign ram_dout = pv[LAT-1] ? pd[LAT-1] : garb;

    typedef struct {
        int            c;
        logic [AW-1:0] a;
        logic          we;
        logic [31:0]   d;
    } iss_t;

    typedef struct {
        int          c;
        logic        rd;
        logic [31:0] d;
    } rsp_t;

    iss_t iq[$];
    rsp_t rq0[$];
    rsp_t rq1[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done0 = 0;
    int done1 = 0;

    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", n, cyc, a, e);
        end
    endtask

    // Monitor: compares DUT outputs against the scoreboard every cycle
    initial begin : monitor
        logic [31:0] er0, er1;
        bit          prst, h0, h1, mreq;
        er0 = '0;
        er1 = '0;
        prst = 1'b0;
        forever begin
            @(negedge clk);
            if (prst) begin
                er0 = '0;
                er1 = '0;
                chk("rst_cs", 32'(ram_cs), 32'd0);
                chk("rst_we", 32'(ram_we), 32'd0);
                chk("rst_addr", 32'(ram_addr), 32'd0);
                chk("rst_din", ram_din, 32'd0);
                chk("rst_inst_data", inst_data, 32'd0);
                chk("rst_mem_din", mem_din, 32'd0);
            end
            if (rst) begin
                chk("rst_inst_stall", 32'(inst_stall), 32'd0);
                chk("rst_data_stall", 32'(data_stall), 32'd0);
                prst = 1'b1;
            end else begin
                prst = 1'b0;
                mreq = mem_ren | mem_wen;
                h0 = rq0.size() > 0 && rq0[0].c == cyc;
                h1 = rq1.size() > 0 && rq1[0].c == cyc;
                chk("inst_stall", 32'(inst_stall), 32'(inst_ren & ~h0));
                chk("data_stall", 32'(data_stall), 32'(mreq & ~h1));
                if (inst_ren && !inst_stall) done0++;
                if (mreq && !data_stall) done1++;
                if (h0) begin
                    if (rq0[0].rd) er0 = rq0[0].d;
                    void'(rq0.pop_front());
                end
                if (h1) begin
                    if (rq1[0].rd) er1 = rq1[0].d;
                    void'(rq1.pop_front());
                end
                chk("inst_data", inst_data, er0);
                chk("mem_din", mem_din, er1);
                if (iq.size() > 0 && iq[0].c == cyc) begin
                    chk("ram_cs", 32'(ram_cs), 32'd1);
                    chk("ram_addr", 32'(ram_addr), 32'(iq[0].a));
                    chk("ram_we", 32'(ram_we), 32'(iq[0].we));
                    if (iq[0].we) chk("ram_din", ram_din, iq[0].d);
                    void'(iq.pop_front());
                end else begin
                    chk("ram_cs_idle", 32'(ram_cs), 32'd0);
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog");
    end

    // Core-side agent and transaction-level arbiter model
    bit          act [2];
    bit          pend [2];
    logic [31:0] ad [2];
    bit          we1, rd1;
    logic [31:0] wd1;
    int          seen0 = 0;
    int          seen1 = 0;
    int          free_c = 0;
    bit          rr_dl = 1'b1;
    logic [31:0] refm [1<<AW];

    task automatic drive();
        inst_ren  = act[0];
        inst_addr = ad[0];
        mem_ren   = act[1] & rd1;
        mem_wen   = act[1] & we1;
        mem_addr  = ad[1];
        mem_dout  = wd1;
    endtask

    // One access occupies grant, issue, (LAT wait), resp; next grant after
    task automatic sched();
        int            w;
        logic [AW-1:0] wa;
        bit            wr;
        int            r;
        iss_t          it;
        rsp_t          rs;
        if (rst || cyc < free_c || !(pend[0] || pend[1])) return;
        if (pend[0] && pend[1]) begin
`ifdef MEM_ARB_RR_EN
            w = rr_dl ? 0 : 1;
            rr_dl = (w == 1);
`else
            w = 1;
`endif
        end else begin
            w = pend[1] ? 1 : 0;
        end
        wa = ad[w][AW+1:2];
        wr = (w == 1) && we1;
        r = wr ? cyc + 2 : cyc + 2 + LAT;
        it.c = cyc + 1;
        it.a = wa;
        it.we = wr;
        it.d = wd1;
        iq.push_back(it);
        if (wr) refm[wa] = wd1;
        rs.c = r;
        rs.rd = !wr;
        rs.d = refm[wa];
        if (w == 0) rq0.push_back(rs);
        else rq1.push_back(rs);
        pend[w] = 1'b0;
        free_c = r + 1;
    endtask

    task automatic step();
        drive();
        sched();
        @(posedge clk);
        #1;
        cyc++;
        if (done0 != seen0) begin
            seen0 = done0;
            act[0] = 1'b0;
        end
        if (done1 != seen1) begin
            seen1 = done1;
            act[1] = 1'b0;
        end
    endtask

    task automatic req_i(logic [31:0] a);
        act[0] = 1'b1;
        pend[0] = 1'b1;
        ad[0] = a;
    endtask

    task automatic req_d(bit w, bit r, logic [31:0] a, logic [31:0] d);
        act[1] = 1'b1;
        pend[1] = 1'b1;
        we1 = w;
        rd1 = r;
        ad[1] = a;
        wd1 = d;
    endtask

    task automatic wait_free(int maxc);
        for (int i = 0; i < maxc && (act[0] || act[1]); i++) step();
    endtask

    task automatic do_reset(int n);
        rst = 1'b1;
        act[0] = 1'b0;
        act[1] = 1'b0;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        iq.delete();
        rq0.delete();
        rq1.delete();
        rr_dl = 1'b1;
        repeat (n) step();
        rst = 1'b0;
        free_c = cyc;
    endtask

    function automatic logic [31:0] raddr();
        return ($urandom & 32'hFFFF_F003)
             | (32'($urandom_range(0, 15)) << 2);
    endfunction

    initial begin : stim
        for (int i = 0; i < (1 << AW); i++) refm[i] = f_init(i);
        ad[0] = '0;
        ad[1] = '0;
        wd1 = '0;
        we1 = 1'b1;
        rd1 = 1'b0;
        // Requests held high during reset must not see a stall
        rst = 1'b1;
        act[0] = 1'b1;
        act[1] = 1'b1;
        repeat (3) step();
        act[0] = 1'b0;
        act[1] = 1'b0;
        rst = 1'b0;
        free_c = cyc;
        step();

        req_i(32'h0000_0008);
        wait_free(20);
        step();

        req_d(1'b1, 1'b0, 32'h0000_0040, 32'hDEAD_BEEF);
        wait_free(20);
        req_d(1'b0, 1'b1, 32'h0000_0040, 32'h0);
        wait_free(20);
        step();

        repeat (2) begin
            req_i(32'h0000_0000);
            req_d(1'b0, 1'b1, 32'h0000_0004, 32'h0);
            wait_free(30);
            step();
        end

        // Fetch flushed mid-access: data register still updates
        req_i(32'h0000_0010);
        step();
        step();
        act[0] = 1'b0;
        repeat (6) step();

        repeat (400) begin
            if (!act[0] && $urandom_range(0, 2) == 0) req_i(raddr());
            if (!act[1] && $urandom_range(0, 2) == 0)
                req_d(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      raddr(), $urandom);
            if (act[1] && !we1) rd1 = 1'b1;
            step();
        end
        wait_free(60);
        step();

        // Reset during WAIT of a read, then wrap-around address
        req_i(32'h0000_0020);
        step();
        step();
        step();
        do_reset(1);
        req_i(32'hFFFF_FFFC);
        wait_free(20);
        repeat (4) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
